// File: rtl/systolic_feed_ctrl_if.sv
// Bundle between the tile feed controller, its host, the A/B tile buffers and the PE grid edges.
interface systolic_feed_ctrl_if #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K_MAX      = 16
);
  localparam int unsigned KW = $clog2(K_MAX + 1);
  localparam int unsigned AW = $clog2(K_MAX);

  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    busy;
  logic                    done;
  logic                    array_clr;
  logic                    a_rd_en;
  logic [AW-1:0]           a_rd_addr;
  logic [N*DATA_WIDTH-1:0] a_rd_data;
  logic                    b_rd_en;
  logic [AW-1:0]           b_rd_addr;
  logic [N*DATA_WIDTH-1:0] b_rd_data;
  logic [N*DATA_WIDTH-1:0] west_data;
  logic [N*DATA_WIDTH-1:0] north_data;

  // Environment side: host control, buffer read data, grid consumes edges
  modport master (
    output start, k_len, a_rd_data, b_rd_data,
    input  busy, done, array_clr, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           west_data, north_data
  );

  // Controller side
  modport slave (
    input  start, k_len, a_rd_data, b_rd_data,
    output busy, done, array_clr, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           west_data, north_data
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequences one N x N output-stationary tile: clear grid, feed K A-columns/B-rows
// with diagonal skew onto the west/north edges, drain the wavefront, pulse done.
module systolic_feed_ctrl #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K_MAX      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_feed_ctrl_if.slave   bus
);
  localparam int unsigned KW         = $clog2(K_MAX + 1);
  localparam int unsigned AW         = $clog2(K_MAX);
  localparam int unsigned CW         = $clog2(2 * N);
  localparam int unsigned DRAIN_LAST = 2 * N - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [KW-1:0] kl, kl_nx;
  logic [KW-1:0] kcnt, kcnt_nx;
  logic [CW-1:0] dcnt, dcnt_nx;

  logic          busy_q, done_q, clr_q, rd_en_q, rd_vld;
  logic [AW-1:0] addr_q, addr_nx;

  logic [DATA_WIDTH-1:0] a_in       [N];
  logic [DATA_WIDTH-1:0] b_in       [N];
  logic [DATA_WIDTH-1:0] west_lane  [N];
  logic [DATA_WIDTH-1:0] north_lane [N];
  logic [N*DATA_WIDTH-1:0] west_pack, north_pack;

  // State and tile counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      kl    <= '0;
      kcnt  <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      kl    <= kl_nx;
      kcnt  <= kcnt_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // Next-state, counter and read-address decode
  always_comb begin
    state_nx = state;
    kl_nx    = kl;
    kcnt_nx  = kcnt;
    dcnt_nx  = dcnt;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          kl_nx    = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
          state_nx = S_CLEAR;
        end
      end
      S_CLEAR: begin
        kcnt_nx  = '0;
        state_nx = (kl == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (kcnt == kl - KW'(1)) begin
          kcnt_nx  = '0;
          dcnt_nx  = '0;
          state_nx = S_DRAIN;
        end else begin
          kcnt_nx = kcnt + KW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt == CW'(DRAIN_LAST)) begin
          dcnt_nx  = '0;
          state_nx = S_DONE;
        end else begin
          dcnt_nx = dcnt + CW'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    addr_nx = (state_nx == S_FEED) ? kcnt_nx[AW-1:0] : '0;
  end

  // Registered control outputs, decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b1;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      rd_vld  <= 1'b0;
    end else begin
      busy_q  <= (state_nx != S_IDLE);
      done_q  <= (state_nx == S_DONE);
      clr_q   <= (state_nx == S_CLEAR);
      rd_en_q <= (state_nx == S_FEED);
      addr_q  <= addr_nx;
      rd_vld  <= rd_en_q;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.array_clr = clr_q;
  assign bus.a_rd_en   = rd_en_q;
  assign bus.b_rd_en   = rd_en_q;
  assign bus.a_rd_addr = addr_q;
  assign bus.b_rd_addr = addr_q;

  // Mask buffer data outside valid read cycles so bubbles carry zero operands
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = rd_vld ? bus.a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_in[i] = rd_vld ? bus.b_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  // Lane g of each edge is delayed by g register stages to form the diagonal wavefront
  for (genvar g = 0; g < N; g++) begin : g_skew
    if (g == 0) begin : g_pass
      assign west_lane[g]  = a_in[g];
      assign north_lane[g] = b_in[g];
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] a_pipe [g];
      logic [DATA_WIDTH-1:0] b_pipe [g];

      // Skew shift register for this lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < g; s++) begin
            a_pipe[s] <= '0;
            b_pipe[s] <= '0;
          end
        end else begin
          a_pipe[0] <= a_in[g];
          b_pipe[0] <= b_in[g];
          for (int s = 1; s < g; s++) begin
            a_pipe[s] <= a_pipe[s-1];
            b_pipe[s] <= b_pipe[s-1];
          end
        end
      end

      assign west_lane[g]  = a_pipe[g-1];
      assign north_lane[g] = b_pipe[g-1];
    end
  end

  // Pack lanes onto the edge buses
  always_comb begin
    west_pack  = '0;
    north_pack = '0;
    for (int i = 0; i < N; i++) begin
      west_pack[i*DATA_WIDTH +: DATA_WIDTH]  = west_lane[i];
      north_pack[i*DATA_WIDTH +: DATA_WIDTH] = north_lane[i];
    end
  end

  assign bus.west_data  = west_pack;
  assign bus.north_data = north_pack;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: buffer model, behavioural PE grid, result scoreboard.
module tb_systolic_feed_ctrl;
  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned K_MAX = 16;
  localparam int unsigned KW    = $clog2(K_MAX + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) bus ();

  systolic_feed_ctrl #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int kl;
    int res [N][N];
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Tile buffer contents: a_mem[k][i] = A[i][k], b_mem[k][j] = B[k][j]
  logic [DW-1:0] a_mem [K_MAX][N];
  logic [DW-1:0] b_mem [K_MAX][N];

  // Buffer model: data one cycle after read strobe, garbage otherwise
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      bus.a_rd_data[i*DW +: DW] <= bus.a_rd_en ? a_mem[bus.a_rd_addr][i] : DW'($urandom_range(1, 255));
      bus.b_rd_data[i*DW +: DW] <= bus.b_rd_en ? b_mem[bus.b_rd_addr][i] : DW'($urandom_range(1, 255));
    end
  end

  // Behavioural output-stationary PE grid fed by the edges
  int            acc [N][N];
  logic [DW-1:0] pw  [N][N];
  logic [DW-1:0] pn  [N][N];
  logic [N*DW-1:0] w_s, n_s;
  logic          clr_s = 1'b1;

  always @(negedge clk) begin
    w_s   = bus.west_data;
    n_s   = bus.north_data;
    clr_s = bus.array_clr;
  end

  always @(posedge clk) begin
    logic [DW-1:0] w, n;
    for (int i = N - 1; i >= 0; i--) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (clr_s) begin
          acc[i][j] = 0;
          pw[i][j]  = '0;
          pn[i][j]  = '0;
        end else begin
          if (j == 0) w = w_s[i*DW +: DW];
          else        w = pw[i][j-1];
          if (i == 0) n = n_s[j*DW +: DW];
          else        n = pn[i-1][j];
          acc[i][j] = acc[i][j] + int'(w) * int'(n);
          pw[i][j]  = w;
          pn[i][j]  = n;
        end
      end
    end
  end

  // Per-tile monitor and scoreboard checker
  int   cyc = 0;
  int   t0 = 0, busy_cnt = 0, clr_cnt = 0, rd_cnt = 0, wl_first = -1, wl_cnt = 0;
  logic busy_q = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (bus.busy && !busy_q) begin
      t0 = cyc; busy_cnt = 0; clr_cnt = 0; rd_cnt = 0; wl_first = -1; wl_cnt = 0;
    end
    busy_q = bus.busy;
    if (bus.busy) begin
      busy_cnt++;
      if (bus.array_clr) clr_cnt++;
    end
    if (bus.a_rd_en) begin
      chk("a_addr", int'(bus.a_rd_addr), rd_cnt);
      chk("b_addr", int'(bus.b_rd_addr), rd_cnt);
      chk("b_en", int'(bus.b_rd_en), 1);
      rd_cnt++;
    end
    if (bus.west_data[(N-1)*DW +: DW] != '0) begin
      if (wl_first < 0) wl_first = cyc - t0;
      wl_cnt++;
    end
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - t0, (e.kl == 0) ? 1 : e.kl + 2 * N);
        chk("busy_cycles", busy_cnt, (e.kl == 0) ? 2 : e.kl + 2 * N + 1);
        chk("clr_pulses", clr_cnt, 1);
        chk("reads", rd_cnt, e.kl);
        chk("busy_at_done", int'(bus.busy), 1);
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("pe_%0d_%0d", i, j), acc[i][j], e.res[i][j]);
      end
    end
  end

  task automatic start_tile(input int kl_in);
    exp_t e;
    e.kl = (kl_in > int'(K_MAX)) ? int'(K_MAX) : kl_in;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e.res[i][j] = 0;
        for (int k = 0; k < e.kl; k++)
          e.res[i][j] += int'(a_mem[k][i]) * int'(b_mem[k][j]);
      end
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(kl_in);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, int'(n < 400), 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_feed_addr(input string tag, input int addr);
    int n = 0;
    while (!(bus.a_rd_en && int'(bus.a_rd_addr) == addr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach"}, int'(n < 50), 1);
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: begin a_mem[k][i] = '0; b_mem[k][i] = '0; end
          1: begin a_mem[k][i] = DW'(i == k); b_mem[k][i] = DW'(k * N + i + 1); end
          2: begin a_mem[k][i] = 8'd2; b_mem[k][i] = 8'd2; end
          3: begin a_mem[k][i] = 8'd1; b_mem[k][i] = 8'd1; end
          default: begin
            a_mem[k][i] = DW'($urandom_range(0, 15));
            b_mem[k][i] = DW'($urandom_range(0, 15));
          end
        endcase
      end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_clr"}, int'(bus.array_clr), 1);
    chk({tag, "_rd_en"}, int'(bus.a_rd_en | bus.b_rd_en), 0);
    chk({tag, "_addr"}, int'(bus.a_rd_addr) + int'(bus.b_rd_addr), 0);
    chk({tag, "_edges"}, int'((bus.west_data | bus.north_data) != '0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    rst_n     = 1'b0;
    fill(0);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("clr_release", int'(bus.array_clr), 0);

    // Identity A, B = 1..16: grid reproduces B
    fill(1);
    start_tile(4);
    wait_idle("t1");

    // K=1 outer product; last west lane carries a value exactly once
    fill(0);
    for (int i = 0; i < N; i++) begin
      a_mem[0][i] = DW'(i + 1);
      b_mem[0][i] = DW'(i + 5);
    end
    start_tile(1);
    wait_idle("t2");
    chk("t2_wl_first", wl_first, N + 1);
    chk("t2_wl_cnt", wl_cnt, 1);

    // Empty tile: clear then done, no reads
    fill(4);
    start_tile(0);
    wait_idle("t3");

    // Oversized k_len clamps; a start during FEED is ignored
    fill(4);
    start_tile(K_MAX + 5);
    wait_feed_addr("t4", 3);
    bus.start = 1'b1;
    bus.k_len = KW'(2);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("t4");

    // Back-to-back tiles must not accumulate across the clear
    fill(2);
    start_tile(3);
    wait_idle("t5a");
    fill(3);
    start_tile(2);
    wait_idle("t5b");

    // Reset mid-feed aborts, then a fresh tile runs correctly
    fill(4);
    start_tile(5);
    wait_feed_addr("t6", 2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_abort");
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_tile(5);
    wait_idle("t6");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
